// File: rtl/obuf_reader_if.sv
// ---------------------------------------------------------------------------
// obuf_reader_if
// Bundles the output-buffer FIFO read port and the downstream pixel
// valid/ready stream of obuf_reader.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface obuf_reader_if;
   // FIFO read side
   logic        o_obuf_rd;
   logic [15:0] i_obuf_data;
   logic        i_obuf_empty;
   // Downstream pixel stream
   logic        o_pix_valid;
   logic        i_pix_ready;
   logic [15:0] o_pix_data;
   logic [9:0]  o_pix_x;
   logic [8:0]  o_pix_y;
   logic        o_pix_sof;
   logic        o_pix_eol;
   logic        o_pix_eof;

   // Reader side
   modport master (
      output o_obuf_rd,
      input  i_obuf_data,
      input  i_obuf_empty,
      output o_pix_valid,
      input  i_pix_ready,
      output o_pix_data,
      output o_pix_x,
      output o_pix_y,
      output o_pix_sof,
      output o_pix_eol,
      output o_pix_eof
   );

   // FIFO / consumer side
   modport slave (
      input  o_obuf_rd,
      output i_obuf_data,
      output i_obuf_empty,
      input  o_pix_valid,
      output i_pix_ready,
      input  o_pix_data,
      input  o_pix_x,
      input  o_pix_y,
      input  o_pix_sof,
      input  o_pix_eol,
      input  o_pix_eof
   );
endinterface

`default_nettype wire

// File: rtl/obuf_reader.sv
// ---------------------------------------------------------------------------
// obuf_reader
// Reads RGB565 words from the output-buffer FIFO, tags them with frame
// coordinates and start/end flags, and presents them on a valid/ready
// stream through a 3-entry skid buffer. Words arriving outside a frame
// are drained and counted.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module obuf_reader #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480
) (
   input  wire logic        i_clk,
   input  wire logic        i_rst,
   input  wire logic        i_enable,
   input  wire logic        i_frame_start,
   obuf_reader_if.master    bus,
   output logic             o_err_short,
   output logic [15:0]      o_drop_cnt
);

   localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
   localparam logic [8:0] Y_LAST = 9'(V_ACTIVE - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_SOF = 2'd1,
      ACTIVE   = 2'd2
   } state_t;

   typedef struct packed {
      logic [15:0] data;
      logic [9:0]  x;
      logic [8:0]  y;
      logic        sof;
      logic        eol;
      logic        eof;
   } entry_t;

   state_t      state;
   state_t      state_nxt;

   entry_t      fifo_mem [3];
   entry_t      head;
   entry_t      new_entry;
   logic [1:0]  count;
   logic [1:0]  wr_ptr;
   logic [1:0]  rd_ptr;
   logic        inflight;
   logic [9:0]  wx;
   logic [8:0]  wy;
   logic [15:0] drop_cnt;
   logic        err_short;

   logic        pix_valid;
   logic        pop;
   logic        wr;
   logic        rd;
   logic        drop;
   logic        restart;
   logic        frame_done;
   logic        flush;
   logic        err_nxt;

   assign head       = fifo_mem[rd_ptr];
   assign pix_valid  = (count != 2'd0);
   assign pop        = pix_valid && bus.i_pix_ready;
   // The frame ends when the pixel carrying eof is accepted downstream.
   assign frame_done = (state == ACTIVE) && pop && head.eof;
   assign restart    = i_enable && i_frame_start && (state != IDLE);
   // Disable, restart and frame end all abandon whatever is buffered or in flight.
   assign flush      = !i_enable || restart || frame_done;
   // Issue a read only when the returning word is guaranteed a buffer slot;
   // the downstream ready is deliberately not part of this decision.
   assign rd         = (state != IDLE) && !bus.i_obuf_empty &&
                       (({1'b0, count} + {2'b00, inflight}) < 3'd3) &&
                       i_enable && !i_frame_start;
   assign wr         = (state == ACTIVE) && inflight && !flush;
   assign drop       = (state == WAIT_SOF) && inflight;
   assign err_nxt    = (state == ACTIVE) && i_enable && i_frame_start && !frame_done;

   assign new_entry.data = bus.i_obuf_data;
   assign new_entry.x    = wx;
   assign new_entry.y    = wy;
   assign new_entry.sof  = (wx == 10'd0) && (wy == 9'd0);
   assign new_entry.eol  = (wx == X_LAST);
   assign new_entry.eof  = (wx == X_LAST) && (wy == Y_LAST);

   assign bus.o_obuf_rd   = rd;
   assign bus.o_pix_valid = pix_valid;
   assign bus.o_pix_data  = pix_valid ? head.data : 16'd0;
   assign bus.o_pix_x     = pix_valid ? head.x    : 10'd0;
   assign bus.o_pix_y     = pix_valid ? head.y    : 9'd0;
   assign bus.o_pix_sof   = pix_valid && head.sof;
   assign bus.o_pix_eol   = pix_valid && head.eol;
   assign bus.o_pix_eof   = pix_valid && head.eof;
   assign o_err_short     = err_short;
   assign o_drop_cnt      = drop_cnt;

   // State register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; disable overrides everything
   always_comb begin
      state_nxt = state;
      if (!i_enable) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:     state_nxt = WAIT_SOF;
            WAIT_SOF: if (i_frame_start) state_nxt = ACTIVE;
            ACTIVE: begin
               if (i_frame_start)   state_nxt = ACTIVE;
               else if (frame_done) state_nxt = WAIT_SOF;
            end
            default:  state_nxt = IDLE;
         endcase
      end
   end

   // Buffer storage; entries are only meaningful below count, so no reset
   always_ff @(posedge i_clk) begin
      if (wr) begin
         fifo_mem[wr_ptr] <= new_entry;
      end
   end

   // Buffer pointers, occupancy, in-flight tracking and write-side coordinates
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         count    <= 2'd0;
         wr_ptr   <= 2'd0;
         rd_ptr   <= 2'd0;
         inflight <= 1'b0;
         wx       <= 10'd0;
         wy       <= 9'd0;
      end else begin
         inflight <= rd;
         if (flush) begin
            count  <= 2'd0;
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            wx     <= 10'd0;
            wy     <= 9'd0;
         end else begin
            if (wr) begin
               wr_ptr <= (wr_ptr == 2'd2) ? 2'd0 : wr_ptr + 2'd1;
               if (wx == X_LAST) begin
                  wx <= 10'd0;
                  wy <= (wy == Y_LAST) ? 9'd0 : wy + 9'd1;
               end else begin
                  wx <= wx + 10'd1;
               end
            end
            if (pop) begin
               rd_ptr <= (rd_ptr == 2'd2) ? 2'd0 : rd_ptr + 2'd1;
            end
            case ({wr, pop})
               2'b10:   count <= count + 2'd1;
               2'b01:   count <= count - 2'd1;
               default: count <= count;
            endcase
         end
      end
   end

   // Short-frame pulse and saturating drop counter
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         err_short <= 1'b0;
         drop_cnt  <= 16'd0;
      end else begin
         err_short <= err_nxt;
         if (drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
         end
      end
   end

   // A returning word must always find a free slot
   a_no_write_when_full : assert property (@(posedge i_clk) disable iff (i_rst)
      !(wr && (count == 2'd3)));

endmodule

`default_nettype wire

// File: tb/tb_obuf_reader.sv
// ---------------------------------------------------------------------------
// tb_obuf_reader
// Directed plus randomized bench for obuf_reader with a 4x2 frame. A queue
// models the upstream FIFO; a frame-level scoreboard predicts the pixel
// stream from pixel index and the words fetched since the last frame start.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_obuf_reader;
   localparam int H = 4;
   localparam int V = 2;
   localparam int M_OFF  = 0;
   localparam int M_WAIT = 1;
   localparam int M_ACT  = 2;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_enable;
   logic        i_frame_start;
   logic        o_err_short;
   logic [15:0] o_drop_cnt;

   obuf_reader_if bus ();

   obuf_reader #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_enable      (i_enable),
      .i_frame_start (i_frame_start),
      .bus           (bus),
      .o_err_short   (o_err_short),
      .o_drop_cnt    (o_drop_cnt)
   );

   always #5 i_clk = ~i_clk;

   int          n_assert = 0;
   int          n_fail   = 0;
   int          mode     = M_OFF;
   logic [15:0] fifo_q [$];
   logic [15:0] exp_q  [$];
   int          pix_idx = 0;
   logic [15:0] exp_drops = 16'd0;
   logic        exp_err = 1'b0;
   logic        prev_stall = 1'b0;
   logic [15:0] prev_data;
   logic [9:0]  prev_x;
   logic [8:0]  prev_y;
   logic [2:0]  prev_flags;
   int          cyc = 0;
   int          hs_total = 0;
   int          first_hs = -1;
   int          last_hs = -1;
   int          frames_done = 0;
   int          err_seen = 0;
   logic        pending = 1'b0;
   logic [15:0] pending_word = 16'd0;
   logic [3:0]  ready_pat = 4'b1001;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [15:0] w);
      fifo_q.push_back(w);
      bus.i_obuf_empty = 1'b0;
   endtask

   task automatic model_reset();
      mode       = M_OFF;
      exp_q.delete();
      pix_idx    = 0;
      exp_err    = 1'b0;
      prev_stall = 1'b0;
      exp_drops  = 16'd0;
      pending    = 1'b0;
   endtask

   task automatic reset_checks(input string tag);
      check({tag, "_rd"},    bus.o_obuf_rd,   1'b0);
      check({tag, "_valid"}, bus.o_pix_valid, 1'b0);
      check({tag, "_data"},  bus.o_pix_data,  16'd0);
      check({tag, "_x"},     bus.o_pix_x,     10'd0);
      check({tag, "_y"},     bus.o_pix_y,     9'd0);
      check({tag, "_flags"}, {bus.o_pix_sof, bus.o_pix_eol, bus.o_pix_eof}, 3'b000);
      check({tag, "_err"},   o_err_short,     1'b0);
      check({tag, "_drop"},  o_drop_cnt,      16'd0);
   endtask

   // One clock: sample and score at negedge, advance the FIFO model after posedge
   task automatic cycle();
      logic        hs, rdn, fsn, disn;
      int          q_before;
      logic [15:0] w;
      @(negedge i_clk);
      cyc++;
      hs   = bus.o_pix_valid && bus.i_pix_ready;
      rdn  = bus.o_obuf_rd;
      fsn  = i_enable && i_frame_start;
      disn = !i_enable;
      q_before = exp_q.size();
      pending = 1'b0;
      if (i_rst) begin
         check("in_reset_valid", bus.o_pix_valid, 1'b0);
      end else begin
         check("err_short", o_err_short, exp_err);
         if (o_err_short) err_seen++;
         exp_err = 1'b0;
         if (mode != M_ACT) check("valid_outside_frame", bus.o_pix_valid, 1'b0);
         if (prev_stall) begin
            check("stall_data",  bus.o_pix_data, prev_data);
            check("stall_xy",    {bus.o_pix_x, bus.o_pix_y}, {prev_x, prev_y});
            check("stall_flags", {bus.o_pix_sof, bus.o_pix_eol, bus.o_pix_eof}, prev_flags);
         end
         if (hs && mode == M_ACT) begin
            hs_total++;
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
            if (exp_q.size() == 0) begin
               check("pix_unexpected", hs, 1'b0);
            end else begin
               w = exp_q.pop_front();
               check("pix_data", bus.o_pix_data, w);
               check("pix_x",    bus.o_pix_x, pix_idx % H);
               check("pix_y",    bus.o_pix_y, pix_idx / H);
               check("pix_sof",  bus.o_pix_sof, pix_idx == 0);
               check("pix_eol",  bus.o_pix_eol, (pix_idx % H) == H - 1);
               check("pix_eof",  bus.o_pix_eof, pix_idx == H * V - 1);
            end
            pix_idx++;
            if (pix_idx == H * V) begin
               mode = M_WAIT;
               exp_q.delete();
               pix_idx = 0;
               frames_done++;
            end
         end
         if (rdn) begin
            check("rd_not_idle", mode == M_OFF, 1'b0);
            check("rd_fifo_nonempty", fifo_q.size() != 0, 1'b1);
            if (mode == M_ACT) check("rd_occupancy_lt3", q_before < 3, 1'b1);
            w = (fifo_q.size() != 0) ? fifo_q.pop_front() : 16'hDEAD;
            pending = 1'b1;
            pending_word = w;
            if (mode == M_ACT) exp_q.push_back(w);
            else if (exp_drops != 16'hFFFF) exp_drops++;
         end
         if (disn) begin
            mode = M_OFF;
            exp_q.delete();
            pix_idx = 0;
         end else if (fsn && mode != M_OFF) begin
            if (mode == M_ACT) exp_err = 1'b1;
            mode = M_ACT;
            exp_q.delete();
            pix_idx = 0;
         end else if (mode == M_OFF) begin
            mode = M_WAIT;
         end
         prev_stall = bus.o_pix_valid && !bus.i_pix_ready && !disn && !fsn;
         prev_data  = bus.o_pix_data;
         prev_x     = bus.o_pix_x;
         prev_y     = bus.o_pix_y;
         prev_flags = {bus.o_pix_sof, bus.o_pix_eol, bus.o_pix_eof};
      end
      @(posedge i_clk);
      #1;
      if (pending) bus.i_obuf_data = pending_word;
      bus.i_obuf_empty = (fifo_q.size() == 0);
   endtask

   task automatic start_frame(input int nwords, input logic [15:0] base);
      i_frame_start = 1'b1;
      for (int k = 0; k < nwords; k++) push(base + 16'(k));
      cycle();
      i_frame_start = 1'b0;
   endtask

   // use_pat=1 applies the 1,0,0,1 ready pattern, otherwise ready stays 1
   task automatic run_frame(input logic use_pat, input int budget);
      int target;
      int n;
      target = frames_done + 1;
      n = 0;
      while (frames_done < target && n < budget) begin
         bus.i_pix_ready = use_pat ? ready_pat[n % 4] : 1'b1;
         cycle();
         n++;
      end
      check("frame_completed", frames_done >= target, 1'b1);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle();
   endtask

   initial begin
      int base_hs;
      int base_err;
      int base_frames;
      int n;

      i_rst = 1'b1;
      i_enable = 1'b0;
      i_frame_start = 1'b0;
      bus.i_pix_ready = 1'b0;
      bus.i_obuf_empty = 1'b1;
      bus.i_obuf_data = 16'd0;
      repeat (2) @(posedge i_clk);
      #1;
      reset_checks("reset");
      model_reset();
      i_rst = 1'b0;

      // Frame of 8 words with ready held high
      i_enable = 1'b1;
      idle(3);
      first_hs = -1;
      base_hs = hs_total;
      start_frame(8, 16'h0001);
      run_frame(1'b0, 40);
      check("t1_pixel_count", hs_total - base_hs, 8);
      check("t1_back_to_back", last_hs - first_hs, 7);

      // Words arriving while waiting for a frame start are drained
      bus.i_pix_ready = 1'b1;
      for (int k = 0; k < 3; k++) push(16'h0100 + 16'(k));
      idle(8);
      check("t3_drop_cnt", o_drop_cnt, exp_drops);
      check("t3_drop_cnt_is_3", o_drop_cnt, 16'd3);

      // Same frame with ready pattern 1,0,0,1
      base_hs = hs_total;
      start_frame(8, 16'h0001);
      run_frame(1'b1, 80);
      check("t2_pixel_count", hs_total - base_hs, 8);

      // Frame restart after 5 accepted pixels
      bus.i_pix_ready = 1'b1;
      base_err = err_seen;
      base_hs  = hs_total;
      start_frame(16, 16'h0200);
      n = 0;
      while (hs_total < base_hs + 5 && n < 40) begin
         cycle();
         n++;
      end
      check("t4_reached_5", hs_total >= base_hs + 5, 1'b1);
      i_frame_start = 1'b1;
      cycle();
      i_frame_start = 1'b0;
      run_frame(1'b0, 60);
      check("t4_err_pulses", err_seen - base_err, 1);
      idle(12);
      check("t4_drop_cnt", o_drop_cnt, exp_drops);

      // Reset with two pixels buffered and one in flight
      bus.i_pix_ready = 1'b0;
      start_frame(8, 16'h0300);
      idle(3);
      check("t5_pre_reset_valid", bus.o_pix_valid, 1'b1);
      i_rst = 1'b1;
      #1;
      reset_checks("t5_async");
      model_reset();
      idle(2);
      i_rst = 1'b0;
      bus.i_pix_ready = 1'b1;
      idle(12);
      check("t5_drop_after_release", o_drop_cnt, exp_drops);
      base_hs = hs_total;
      start_frame(8, 16'h0400);
      run_frame(1'b0, 40);
      check("t5_new_frame_pixels", hs_total - base_hs, 8);

      // Disable mid-frame, then re-enable without a frame start
      base_hs = hs_total;
      start_frame(8, 16'h0500);
      n = 0;
      while (hs_total < base_hs + 3 && n < 40) begin
         cycle();
         n++;
      end
      i_enable = 1'b0;
      cycle();
      check("t6_valid_after_disable", bus.o_pix_valid, 1'b0);
      check("t6_rd_after_disable", bus.o_obuf_rd, 1'b0);
      i_enable = 1'b1;
      base_frames = frames_done;
      base_hs = hs_total;
      idle(12);
      check("t6_no_pixels_without_sof", hs_total - base_hs, 0);
      check("t6_no_frame", frames_done - base_frames, 0);
      start_frame(8, 16'h0600);
      run_frame(1'b0, 40);

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         bus.i_pix_ready = ($urandom_range(0, 3) != 0);
         i_frame_start   = ($urandom_range(0, 59) == 0);
         i_enable        = ($urandom_range(0, 199) != 0);
         if (fifo_q.size() < 12 && $urandom_range(0, 3) != 0) push(16'($urandom));
         cycle();
      end
      i_enable = 1'b1;
      i_frame_start = 1'b0;
      bus.i_pix_ready = 1'b1;
      n = 0;
      while (fifo_q.size() != 0 && n < 100) begin
         cycle();
         n++;
      end
      idle(4);
      check("rand_drop_cnt", o_drop_cnt, exp_drops);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
